// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one full-adder cell with a registered carry
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, s_sh_q, s_sh_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s, c, last;

    always_comb begin
        s       = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        c       = (a_sh_q[0] & b_sh_q[0]) | ((a_sh_q[0] | b_sh_q[0]) & carry_q);
        last    = cnt_q == CW'(WIDTH - 1);
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (state_q == SHIFT) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            s_sh_d  = {s, s_sh_q[WIDTH-1:1]};
            carry_d = c;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            if (last) begin
                state_d = DONE;
                sum_d   = {s, s_sh_q[WIDTH-1:1]};
                cout_d  = c;
            end
        end else if (start) begin
            state_d = SHIFT;
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = cin;
            cnt_d   = '0;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = state_q == SHIFT;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and an exhaustive WIDTH=4 sweep
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
    logic [3:0] a4 = '0, b4 = '0, sum4;

    int         checks = 0, errors = 0;
    int         n_done8 = 0, n_done4 = 0;
    bit         mon_en = 1'b0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];
    logic [8:0] hold8 = '0;
    logic [4:0] hold4 = '0;

    serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
                                  .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
    serial_adder #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
                                  .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        if (done8) begin
            if (q8.size() == 0) chk("done8_unexpected", 1, 0);
            else chk("res8", {cout8, sum8}, q8.pop_front());
            hold8 = {cout8, sum8};
            n_done8++;
        end else chk("hold8", {cout8, sum8}, hold8);
        if (done4) begin
            if (q4.size() == 0) chk("done4_unexpected", 1, 0);
            else chk("res4", {cout4, sum4}, q4.pop_front());
            hold4 = {cout4, sum4};
            n_done4++;
        end else chk("hold4", {cout4, sum4}, hold4);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go8(input logic [7:0] x, input logic [7:0] y, input logic c);
        a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
        q8.push_back({1'b0, x} + {1'b0, y} + {8'd0, c});
        step();
        start8 = 1'b0;
    endtask

    task automatic go4(input logic [3:0] x, input logic [3:0] y, input logic c);
        a4 = x; b4 = y; cin4 = c; start4 = 1'b1;
        q4.push_back({1'b0, x} + {1'b0, y} + {4'd0, c});
        step();
        start4 = 1'b0;
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 40) begin
            step();
            n++;
        end
        if (!done8) chk("timeout8", 0, 1);
    endtask

    task automatic wait_done4(output int n);
        n = 0;
        while (!done4 && n < 20) begin
            step();
            n++;
        end
        if (!done4) chk("timeout4", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q8.delete();
        q4.delete();
        hold8 = '0;
        hold4 = '0;
    endtask

    initial begin
        int n, d0;
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", {cout8, sum8}, 0);
        step();
        chk("idle_busy", busy8, 0);

        go8(8'h3C, 8'h42, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("busy_window", busy8, 1);
            chk("no_early_done", done8, 0);
            step();
        end
        chk("done_edge8", done8, 1);
        chk("busy_off", busy8, 0);
        step();
        chk("done_once", done8, 0);

        go8(8'hFF, 8'h01, 1'b0);
        wait_done8(n);
        step();
        go8(8'hA5, 8'h5A, 1'b1);
        wait_done8(n);
        step();

        d0 = n_done8;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h030);
        step();
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1;
        wait_done8(n);
        start8 = 1'b0;
        step();
        chk("held_start_dones", n_done8 - d0, 1);
        chk("held_start_idle", busy8, 0);

        go8(8'h07, 8'h09, 1'b0);
        wait_done8(n);
        go8(8'h01, 8'h01, 1'b1);
        chk("b2b_busy", busy8, 1);
        wait_done8(n);
        chk("b2b_latency", n + 1, 9);
        step();

        d0 = n_done8;
        go8(8'h3C, 8'h42, 1'b0);
        step();
        step();
        do_reset();
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_sum", {cout8, sum8}, 0);
        repeat (12) step();
        chk("abort_no_done", n_done8 - d0, 0);

        rst = 1'b1; start8 = 1'b1;
        step();
        rst = 1'b0; start8 = 1'b0;
        chk("rst_beats_start", busy8, 0);
        step();
        chk("rst_beats_start2", busy8, 0);

        go8(8'h80, 8'h80, 1'b0);
        wait_done8(n);
        step();

        d0 = n_done4;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            go4(v[3:0], v[7:4], v[8]);
            wait_done4(n);
        end
        step();
        chk("done4_count", n_done4 - d0, 512);
        chk("q4_empty", q4.size(), 0);
        chk("q8_empty", q8.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single full-adder cell. The cell's carry is held in a flip-flop between cycles.
- Loads two operands and a carry-in on a start pulse. Then feeds one bit pair per clock, LSB first, into the cell, and shifts the sum bits into a result register.
- Sits directly around the 1-bit full-adder stage: drives its a/b/cin inputs and consumes its s/cout outputs. This trades area for WIDTH cycles of latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request to begin an addition; sampled only when not busy
- a  input  WIDTH  operand A, captured on the accepting edge
- b  input  WIDTH  operand B, captured on the accepting edge
- cin  input  1  carry-in, captured on the accepting edge
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse: sum/cout hold a new result
- sum  output  WIDTH  registered result of a+b+cin, low WIDTH bits
- cout  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, and takes priority over every other input.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry flop and bit counter are all 0.
- State machine: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 is accepted on the next edge.
  - That edge loads a_sh<=a, b_sh<=b, carry<=cin, cnt<=0 and moves to SHIFT. busy becomes 1 after this edge.
  - start=0 stays in IDLE.
- SHIFT, each edge:
  - Full-adder cell inputs are a_sh[0], b_sh[0], carry.
  - s = a_sh[0]^b_sh[0]^carry.
  - c = (a_sh[0]&b_sh[0]) | ((a_sh[0]|b_sh[0])&carry).
  - s_sh <= {s, s_sh[WIDTH-1:1]}; a_sh and b_sh shift right by 1 with zero fill; carry <= c; cnt <= cnt+1.
- SHIFT exit, when cnt==WIDTH-1:
  - The same edge also writes sum <= {s, s_sh[WIDTH-1:1]}, cout <= c and done <= 1.
  - Moves to DONE; busy becomes 0.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0.
  - The next edge clears done.
  - If start=1 on that edge, it is accepted exactly as in IDLE (back-to-back operation) and moves to SHIFT. Otherwise moves to IDLE.
- Latency: the accepting edge is edge 0. done is high in the cycle following edge WIDTH. Throughput is one result per WIDTH+1 cycles.
- Output stability:
  - sum and cout change only on the completion edge; partial results are never visible on sum.
  - They hold their value until the next completion or reset.
- start while busy=1 is ignored, with no effect on the operation in progress. a, b and cin may change freely after the accepting edge.
- Width/cnt rules:
  - cnt is ceil(log2(WIDTH)) bits wide and never exceeds WIDTH-1.
  - Arithmetic is modulo 2^WIDTH on sum, with the overflow bit reported on cout.
- Reset mid-operation:
  - Aborts immediately; returns to IDLE with all reset values. sum and cout clear to 0.
  - done is never pulsed for the aborted operation.
- Simultaneous rst and start: reset wins and start is not accepted.

Test Plan:
- WIDTH=8, a=0x3C, b=0x42, cin=0, start pulsed 1 cycle -> busy high 8 cycles; done pulses once in the cycle after edge 8; sum=0x7E, cout=0.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. sum must not change before done.
- Start held high during busy, with a/b changed mid-operation to 0x11/0x22 -> ignored; first result a=0x10, b=0x20, cin=0 gives sum=0x30, cout=0, done pulses exactly once.
- Back-to-back: start high in the DONE cycle with a=0x01, b=0x01, cin=1 -> accepted with no IDLE cycle; next done 9 cycles later with sum=0x03, cout=0.
- Reset asserted on the 3rd SHIFT cycle -> next cycle busy=0, done=0, sum=0x00, cout=0, no done pulse. A subsequent start computes correctly, e.g. 0x80+0x80+0 -> sum=0x00, cout=1.
- WIDTH=4 exhaustive: all 512 combinations of a, b, cin -> {cout,sum} equals a+b+cin for every case; done count equals start count.
